qtz_seq_ctrl: RTL and testbench



---
 rtl/qtz_seq_ctrl.sv | 114 +++++++++++
 tb/tb_qtz_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/qtz_seq_ctrl.sv
// Quantizer segment sequencer: walks one hypervector through a run-time length
// of segments with back-pressure, optional output buffering, and abort.
module qtz_seq_ctrl #(
    parameter int SEQ_CYCLE_COUNT = 4,
    parameter int CTR_W           = $clog2(SEQ_CYCLE_COUNT),
    parameter int BUF_STAGES      = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             start_mapping,
    input  logic             abort,
    input  logic [CTR_W:0]   seg_count,
    input  logic             out_ready,
    output logic [CTR_W-1:0] ctr,
    output logic             mapping_hv_segment,
    output logic             seg_last,
    output logic             mapping_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAP,
        S_BUFFER,
        S_MAP_DONE
    } state_t;

    localparam logic [CTR_W:0] MAX_LEN  = (CTR_W + 1)'(SEQ_CYCLE_COUNT);
    localparam logic [CTR_W:0] LEN_ONE  = (CTR_W + 1)'(1);
    localparam logic [2:0]     BUF_LAST = 3'((BUF_STAGES == 0) ? 0 : BUF_STAGES - 1);

    state_t           state, state_nxt;
    logic [CTR_W-1:0] ctr_q, ctr_nxt;
    logic [CTR_W:0]   len_q, len_nxt;
    logic [2:0]       buf_cnt, buf_cnt_nxt;

    logic start;
    logic fire;
    logic at_last;

    assign start   = start_mapping && en && !abort;
    assign fire    = (state == S_MAP) && en && out_ready;
    assign at_last = ({1'b0, ctr_q} == (len_q - LEN_ONE));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            ctr_q   <= '0;
            len_q   <= MAX_LEN;
            buf_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ctr_q   <= ctr_nxt;
            len_q   <= len_nxt;
            buf_cnt <= buf_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ctr_nxt     = ctr_q;
        len_nxt     = len_q;
        buf_cnt_nxt = buf_cnt;

        case (state)
            S_IDLE, S_MAP_DONE: begin
                if (start) begin
                    state_nxt   = S_MAP;
                    ctr_nxt     = '0;
                    buf_cnt_nxt = '0;
                    len_nxt     = (seg_count == '0 || seg_count > MAX_LEN) ? MAX_LEN : seg_count;
                end else if (state == S_MAP_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_MAP: begin
                // A stall (en or out_ready low) holds ctr so no position is lost
                if (fire) begin
                    if (at_last) begin
                        ctr_nxt   = '0;
                        state_nxt = (BUF_STAGES == 0) ? S_MAP_DONE : S_BUFFER;
                    end else begin
                        ctr_nxt = ctr_q + CTR_W'(1);
                    end
                end
            end
            S_BUFFER: begin
                if (en) begin
                    if (buf_cnt == BUF_LAST) begin
                        state_nxt   = S_MAP_DONE;
                        buf_cnt_nxt = '0;
                    end else begin
                        buf_cnt_nxt = buf_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort) begin
            state_nxt   = S_IDLE;
            ctr_nxt     = '0;
            buf_cnt_nxt = '0;
        end
    end

    assign ctr                = ctr_q;
    assign mapping_hv_segment = (state == S_MAP);
    assign seg_last           = mapping_hv_segment && at_last;
    assign mapping_done       = (state == S_MAP_DONE);
    assign busy               = (state != S_IDLE);

endmodule

// File: tb/tb_qtz_seq_ctrl.sv
// Directed-vector bench for qtz_seq_ctrl: one instance with a single buffer
// stage and one with none, driven from a shared stimulus table.
module tb_qtz_seq_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic       start_mapping;
    logic       abort;
    logic [2:0] seg_count;
    logic       out_ready;

    logic [1:0] ctr_a, ctr_b;
    logic       seg_a, seg_b;
    logic       last_a, last_b;
    logic       done_a, done_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    qtz_seq_ctrl #(.SEQ_CYCLE_COUNT(4), .BUF_STAGES(1)) dut_a (
        .clk(clk), .nrst(nrst), .en(en), .start_mapping(start_mapping),
        .abort(abort), .seg_count(seg_count), .out_ready(out_ready),
        .ctr(ctr_a), .mapping_hv_segment(seg_a), .seg_last(last_a),
        .mapping_done(done_a), .busy(busy_a)
    );

    qtz_seq_ctrl #(.SEQ_CYCLE_COUNT(4), .BUF_STAGES(0)) dut_b (
        .clk(clk), .nrst(nrst), .en(en), .start_mapping(start_mapping),
        .abort(abort), .seg_count(seg_count), .out_ready(out_ready),
        .ctr(ctr_b), .mapping_hv_segment(seg_b), .seg_last(last_b),
        .mapping_done(done_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Each row: outputs expected in this cycle, then inputs driven for this cycle
    typedef struct {
        logic       st;
        logic       en;
        logic       ab;
        logic       rdy;
        logic [2:0] seg;
        logic       e_seg;
        logic       e_last;
        logic       e_done;
        logic       e_busy;
        logic [1:0] e_ctr;
        logic       dut_b;
    } vec_t;

    vec_t rows[$];

    function automatic vec_t v(input logic st, input logic en_i, input logic ab,
                               input logic rdy, input logic [2:0] seg,
                               input logic es, input logic el, input logic ed,
                               input logic eb, input logic [1:0] ec, input logic db);
        vec_t r;
        r.st = st; r.en = en_i; r.ab = ab; r.rdy = rdy; r.seg = seg;
        r.e_seg = es; r.e_last = el; r.e_done = ed; r.e_busy = eb;
        r.e_ctr = ec; r.dut_b = db;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic use_b,
                               input logic es, input logic el, input logic ed,
                               input logic eb, input logic [1:0] ec);
        logic [1:0] c;
        logic       s, l, d, b;
        c = use_b ? ctr_b  : ctr_a;
        s = use_b ? seg_b  : seg_a;
        l = use_b ? last_b : last_a;
        d = use_b ? done_b : done_a;
        b = use_b ? busy_b : busy_a;
        check({tag, ".ctr"},     int'(c), int'(ec));
        check({tag, ".segment"}, int'(s), int'(es));
        check({tag, ".last"},    int'(l), int'(el));
        check({tag, ".done"},    int'(d), int'(ed));
        check({tag, ".busy"},    int'(b), int'(eb));
    endtask

    task automatic applyStimulus(input vec_t r);
        start_mapping = r.st;
        en            = r.en;
        abort         = r.ab;
        out_ready     = r.rdy;
        seg_count     = r.seg;
    endtask

    initial begin
        // Sequence 1: default length, no stalls, one buffer cycle
        rows.push_back(v(1,1,0,1,0, 0,0,0,0,0, 0));
        rows.push_back(v(0,1,0,1,0, 1,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,0, 1,0,0,1,1, 0));
        rows.push_back(v(0,1,0,1,0, 1,0,0,1,2, 0));
        rows.push_back(v(0,1,0,1,0, 1,1,0,1,3, 0));
        rows.push_back(v(0,1,0,1,0, 0,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,0, 0,0,1,1,0, 0));
        rows.push_back(v(0,1,0,1,0, 0,0,0,0,0, 0));
        // Sequence 2: length 3, out_ready stall then en stall; seg_count changes mid-run
        rows.push_back(v(1,1,0,1,3, 0,0,0,0,0, 0));
        rows.push_back(v(0,1,0,1,1, 1,0,0,1,0, 0));
        rows.push_back(v(0,1,0,0,1, 1,0,0,1,1, 0));
        rows.push_back(v(0,0,0,1,1, 1,0,0,1,1, 0));
        rows.push_back(v(0,1,0,1,1, 1,0,0,1,1, 0));
        rows.push_back(v(0,1,0,1,1, 1,1,0,1,2, 0));
        rows.push_back(v(0,1,0,1,1, 0,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,1, 0,0,1,1,0, 0));
        rows.push_back(v(0,1,0,1,1, 0,0,0,0,0, 0));
        // Sequence 3: no buffer stage, single segment
        rows.push_back(v(1,1,0,1,1, 0,0,0,0,0, 1));
        rows.push_back(v(0,1,0,1,0, 1,1,0,1,0, 1));
        rows.push_back(v(0,1,0,1,0, 0,0,1,1,0, 1));
        rows.push_back(v(0,1,0,1,0, 0,0,0,0,0, 1));
        rows.push_back(v(0,1,0,1,0, 0,0,0,0,0, 1));
        // Sequence 4: start held high, length 2, back-to-back restarts
        rows.push_back(v(1,1,0,1,2, 0,0,0,0,0, 0));
        for (int k = 0; k < 3; k++) begin
            rows.push_back(v(1,1,0,1,2, 1,0,0,1,0, 0));
            rows.push_back(v(1,1,0,1,2, 1,1,0,1,1, 0));
            rows.push_back(v(1,1,0,1,2, 0,0,0,1,0, 0));
            rows.push_back(v(k < 2,1,0,1,2, 0,0,1,1,0, 0));
        end
        rows.push_back(v(0,1,0,1,2, 0,0,0,0,0, 0));
        // Sequence 5: abort with start, then a normal run with an en stall in buffer
        rows.push_back(v(1,1,0,1,0, 0,0,0,0,0, 0));
        rows.push_back(v(0,1,0,1,0, 1,0,0,1,0, 0));
        rows.push_back(v(1,1,1,1,0, 1,0,0,1,1, 0));
        rows.push_back(v(0,1,0,1,0, 0,0,0,0,0, 0));
        rows.push_back(v(1,1,0,1,2, 0,0,0,0,0, 0));
        rows.push_back(v(0,1,0,1,2, 1,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,2, 1,1,0,1,1, 0));
        rows.push_back(v(0,0,0,1,2, 0,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,2, 0,0,0,1,0, 0));
        rows.push_back(v(0,1,0,1,2, 0,0,1,1,0, 0));
        rows.push_back(v(0,1,0,1,2, 0,0,0,0,0, 0));

        nrst          = 1'b0;
        start_mapping = 1'b0;
        abort         = 1'b0;
        en            = 1'b1;
        out_ready     = 1'b1;
        seg_count     = 3'd0;
        #12;
        checkOutput("reset_a", 1'b0, 0,0,0,0,0);
        checkOutput("reset_b", 1'b1, 0,0,0,0,0);
        @(negedge clk);
        nrst = 1'b1;

        foreach (rows[i]) begin
            @(negedge clk);
            checkOutput($sformatf("row%0d", i), rows[i].dut_b, rows[i].e_seg,
                        rows[i].e_last, rows[i].e_done, rows[i].e_busy, rows[i].e_ctr);
            applyStimulus(rows[i]);
        end

        // Asynchronous reset while dut_a sits in its buffer cycle
        @(negedge clk);
        start_mapping = 1'b1;
        seg_count     = 3'd1;
        @(negedge clk);
        start_mapping = 1'b0;
        check("arst.pre_segment", int'(seg_a), 1);
        @(negedge clk);
        check("arst.pre_busy", int'(busy_a), 1);
        check("arst.pre_segment_low", int'(seg_a), 0);
        #2 nrst = 1'b0;
        #1;
        checkOutput("arst.during", 1'b0, 0,0,0,0,0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("arst.after", 1'b0, 0,0,0,0,0);
        start_mapping = 1'b1;
        seg_count     = 3'd0;
        @(negedge clk);
        start_mapping = 1'b0;
        checkOutput("arst.restart", 1'b0, 1,0,0,1,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
